// File: rtl/fifo_flagged.sv
// Single-clock FIFO with level, almost-full/almost-empty and sticky error flags.
// Optional first-word-fall-through mode keeps the head word on data_out.
module fifo_flagged #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 10,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 1,
    localparam int CTR_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 wr_en,
    input  logic                 rd_en,
    input  logic                 err_clr,
    output logic [WIDTH-1:0]     data_out,
    output logic                 empty,
    output logic                 full,
    output logic                 almost_empty,
    output logic                 almost_full,
    output logic [CTR_WIDTH-1:0] level,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW-1:0]        wr_ptr_inc, rd_ptr_inc, head_addr;
    logic                 wr_ok, rd_ok;
    logic [CTR_WIDTH-1:0] level_next;
    logic [CTR_WIDTH-1:0] kept;
    logic [WIDTH-1:0]     dout_next;

    always_comb begin
        wr_ok      = wr_en & ~full;
        rd_ok      = rd_en & ~empty;
        wr_ptr_inc = (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
        rd_ptr_inc = (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
        head_addr  = rd_ok ? rd_ptr_inc : rd_ptr;
        kept       = level - CTR_WIDTH'(rd_ok);

        level_next = level;
        if (wr_ok && !rd_ok)
            level_next = level + CTR_WIDTH'(1);
        else if (rd_ok && !wr_ok)
            level_next = level - CTR_WIDTH'(1);
    end

    // FWFT: present the post-operation head; when nothing older survives the pop,
    // the head is the word being written this edge, so bypass the RAM.
    always_comb begin
        dout_next = data_out;
        if (FWFT != 0) begin
            if (level_next == '0)
                dout_next = '0;
            else if (kept == '0)
                dout_next = data_in;
            else
                dout_next = mem[head_addr];
        end else if (rd_ok) begin
            dout_next = mem[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            data_out     <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr_inc;
            if (rd_ok)
                rd_ptr <= rd_ptr_inc;
            level        <= level_next;
            data_out     <= dout_next;
            empty        <= (level_next == '0);
            full         <= (level_next == CTR_WIDTH'(DEPTH));
            almost_empty <= (level_next <= CTR_WIDTH'(AE_THRESH));
            almost_full  <= (level_next >= CTR_WIDTH'(AF_THRESH));
            // A set event in the same cycle as err_clr keeps the flag raised.
            overflow     <= (wr_en & full)  | (overflow  & ~err_clr);
            underflow    <= (rd_en & empty) | (underflow & ~err_clr);
        end
    end

endmodule
